alu_accum_seq: RTL and testbench

- Parametrised accumulator ALU. Next generation of the 4-bit switch-driven ALU.
- Adds the following over the previous generation:
  - generic operand width
  - a start/busy/done handshake
  - a subtract op
  - a multi-cycle shift-add multiplier
  - zero and carry status flags
- Operand B is always the low WIDTH bits of the accumulator, so operations chain on previous results.
- Sits between board inputs (switches/keys, via debouncing/edge-detect) and the HEX/LED display drivers.

---
 rtl/alu_accum_seq.sv | 160 ++++++++++++++++
 tb/tb_alu_accum_seq.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_accum_seq.sv
// alu_accum_seq: accumulator ALU. Operand B is always acc[WIDTH-1:0], so successive
// operations chain on the previous result. Single-cycle ops complete on the accept edge.
// Multiply (op 111) uses a WIDTH-iteration shift-add datapath.
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  synchronous active-low reset (dominates start)
//   start    request to execute op on a (ignored while busy)
//   op       operation select
//   a        operand A
//   acc      2*WIDTH-bit accumulator / result
//   busy     high while a multiply is in progress
//   done     one-cycle pulse when a result and its flags are valid
//   zero     acc == 0 after the last completed op
//   carry    carry/borrow of the last add/sub, 0 for other ops
module alu_accum_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     a,
    output logic [2*WIDTH-1:0]   acc,
    output logic                 busy,
    output logic                 done,
    output logic                 zero,
    output logic                 carry
);

    localparam int unsigned AccW = 2 * WIDTH;
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e             state_q, state_d;
    logic [AccW-1:0]    acc_q, acc_d;
    logic               done_q, done_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic [AccW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [AccW-1:0]    prod_q, prod_d;
    logic [CntW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0]   b;
    logic [31:0]        a_wide;
    logic [WIDTH:0]     sum_w;
    logic [WIDTH-1:0]   diff;
    logic [AccW-1:0]    prod_sum;

    assign b      = acc_q[WIDTH-1:0];
    assign a_wide = 32'(a);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        done_d   = 1'b0;
        zero_d   = zero_q;
        carry_d  = carry_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        sum_w    = '0;
        diff     = '0;
        // One shift-add step: multiplier is consumed LSB-first, multiplicand shifts left.
        prod_sum = prod_q + (mplier_q[0] ? mcand_q : '0);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    done_d  = 1'b1;
                    carry_d = 1'b0;
                    case (op)
                        3'b000: begin
                            sum_w   = {1'b0, a} + (WIDTH + 1)'(1);
                            acc_d   = AccW'(sum_w);
                            carry_d = sum_w[WIDTH];
                        end
                        3'b001: begin
                            sum_w   = {1'b0, a} + {1'b0, b};
                            acc_d   = AccW'(sum_w);
                            carry_d = sum_w[WIDTH];
                        end
                        3'b010: begin
                            diff    = a - b;
                            acc_d   = AccW'(diff);
                            carry_d = (a < b);
                        end
                        3'b011: acc_d = {a | b, a ^ b};
                        3'b100: acc_d = AccW'(|{a, b});
                        3'b101: acc_d = (a_wide >= AccW) ? '0 : (AccW'(b) << a);
                        3'b110: acc_d = (a_wide >= WIDTH) ? '0 : AccW'(b >> a);
                        3'b111: begin
                            // acc, zero and carry hold until the product is ready.
                            done_d   = 1'b0;
                            carry_d  = carry_q;
                            mcand_d  = AccW'(a);
                            mplier_d = b;
                            prod_d   = '0;
                            cnt_d    = '0;
                            state_d  = StMul;
                        end
                        default: ;
                    endcase
                    if (op != 3'b111) begin
                        zero_d = (acc_d == '0);
                    end
                end
            end
            StMul: begin
                prod_d   = prod_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == LastIter) begin
                    acc_d   = prod_sum;
                    zero_d  = (prod_sum == '0);
                    carry_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            done_q   <= done_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    assign acc   = acc_q;
    assign busy  = (state_q == StMul);
    assign done  = done_q;
    assign zero  = zero_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_alu_accum_seq.sv
// Self-checking bench for alu_accum_seq (WIDTH=4). Observed bundle is
// {acc, busy, done, zero, carry}; expectations come from directed constants
// and a plain-arithmetic reference model.
module tb_alu_accum_seq;

    localparam int unsigned W = 4;
    localparam longint WMASK = (64'd1 << W) - 1;
    localparam longint AMASK = (64'd1 << (2 * W)) - 1;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic [2:0]     op = 3'b000;
    logic [W-1:0]   a = '0;
    logic [2*W-1:0] acc;
    logic           busy, done, zero, carry;
    logic [11:0]    obs;

    int n_checks = 0;
    int n_pass = 0;

    alu_accum_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .acc     (acc),
        .busy    (busy),
        .done    (done),
        .zero    (zero),
        .carry   (carry)
    );

    always #5 clk = ~clk;

    assign obs = {acc, busy, done, zero, carry};

    // Reference model: result of op on (A, B) as unbounded integers, then wrapped.
    function automatic longint model_acc(input int o, input longint av, input longint bv);
        case (o)
            0: return av + 1;
            1: return av + bv;
            2: return (av - bv) & WMASK;
            3: return ((av | bv) << W) | (av ^ bv);
            4: return ((av | bv) != 0) ? 1 : 0;
            5: return (av >= 2 * W) ? 0 : ((bv << av) & AMASK);
            6: return (av >= W) ? 0 : (bv >> av);
            default: return av * bv;
        endcase
    endfunction

    function automatic logic model_carry(input int o, input longint av, input longint bv);
        case (o)
            0: return ((av + 1) >> W) != 0;
            1: return ((av + bv) >> W) != 0;
            2: return av < bv;
            default: return 1'b0;
        endcase
    endfunction

    // Drive one start pulse; returns at the negedge after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] av);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = av;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b1;
        op      = 3'b000;
        a       = 4'h3;
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs !== 12'h000) $display("FAIL reset_dominates_start: got %h want %h", obs, 12'h000);
        else n_pass++;
        start   = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (obs !== 12'h000) $display("FAIL reset_idle: got %h want %h", obs, 12'h000);
        else n_pass++;
    endtask

    task automatic test_add();
        do_reset();
        issue(3'b001, 4'h5);
        n_checks++;
        if (obs !== {8'h05, 4'b0100}) $display("FAIL add_a5: got %h want %h", obs, {8'h05, 4'b0100});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (obs !== {8'h05, 4'b0000}) $display("FAIL add_done_pulse: got %h want %h", obs, {8'h05, 4'b0000});
        else n_pass++;
        issue(3'b001, 4'hC);
        n_checks++;
        if (obs !== {8'h11, 4'b0101}) $display("FAIL add_carry: got %h want %h", obs, {8'h11, 4'b0101});
        else n_pass++;
    endtask

    task automatic test_sub();
        do_reset();
        issue(3'b000, 4'h4);
        n_checks++;
        if (obs !== {8'h05, 4'b0100}) $display("FAIL inc_a4: got %h want %h", obs, {8'h05, 4'b0100});
        else n_pass++;
        issue(3'b010, 4'h3);
        n_checks++;
        if (obs !== {8'h0E, 4'b0101}) $display("FAIL sub_borrow: got %h want %h", obs, {8'h0E, 4'b0101});
        else n_pass++;
        issue(3'b010, 4'hE);
        n_checks++;
        if (obs !== {8'h00, 4'b0110}) $display("FAIL sub_zero: got %h want %h", obs, {8'h00, 4'b0110});
        else n_pass++;
    endtask

    task automatic test_mul();
        do_reset();
        issue(3'b000, 4'hD);
        n_checks++;
        if (obs !== {8'h0E, 4'b0100}) $display("FAIL mul_setup: got %h want %h", obs, {8'h0E, 4'b0100});
        else n_pass++;
        issue(3'b111, 4'hF);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs !== {8'h0E, 4'b1000})
                $display("FAIL mul_busy_%0d: got %h want %h", i, obs, {8'h0E, 4'b1000});
            else n_pass++;
            // Starts and operand changes while busy, including on the completion edge.
            start = (i >= 1);
            op    = 3'($urandom);
            a     = 4'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        n_checks++;
        if (obs !== {8'hD2, 4'b0100}) $display("FAIL mul_done: got %h want %h", obs, {8'hD2, 4'b0100});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (obs !== {8'hD2, 4'b0000}) $display("FAIL mul_after: got %h want %h", obs, {8'hD2, 4'b0000});
        else n_pass++;
    endtask

    task automatic test_shift();
        do_reset();
        issue(3'b000, 4'h2);
        n_checks++;
        if (obs !== {8'h03, 4'b0100}) $display("FAIL shift_setup: got %h want %h", obs, {8'h03, 4'b0100});
        else n_pass++;
        issue(3'b101, 4'h2);
        n_checks++;
        if (obs !== {8'h0C, 4'b0100}) $display("FAIL shl_2: got %h want %h", obs, {8'h0C, 4'b0100});
        else n_pass++;
        issue(3'b110, 4'h2);
        n_checks++;
        if (obs !== {8'h03, 4'b0100}) $display("FAIL shr_2: got %h want %h", obs, {8'h03, 4'b0100});
        else n_pass++;
        issue(3'b101, 4'h9);
        n_checks++;
        if (obs !== {8'h00, 4'b0110}) $display("FAIL shl_over: got %h want %h", obs, {8'h00, 4'b0110});
        else n_pass++;
    endtask

    task automatic test_mul_abort();
        do_reset();
        issue(3'b000, 4'h2);
        issue(3'b111, 4'h5);
        n_checks++;
        if (obs !== {8'h03, 4'b1000}) $display("FAIL abort_busy: got %h want %h", obs, {8'h03, 4'b1000});
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (obs !== 12'h000) $display("FAIL abort_quiet_%0d: got %h want %h", i, obs, 12'h000);
            else n_pass++;
            @(negedge clk);
        end
        issue(3'b000, 4'h7);
        n_checks++;
        if (obs !== {8'h08, 4'b0100}) $display("FAIL abort_next: got %h want %h", obs, {8'h08, 4'b0100});
        else n_pass++;
    endtask

    task automatic test_logic();
        do_reset();
        issue(3'b000, 4'h5);
        issue(3'b011, 4'h3);
        n_checks++;
        if (obs !== {8'h75, 4'b0100}) $display("FAIL orxor: got %h want %h", obs, {8'h75, 4'b0100});
        else n_pass++;
        do_reset();
        issue(3'b100, 4'h0);
        n_checks++;
        if (obs !== {8'h00, 4'b0110}) $display("FAIL redor_0: got %h want %h", obs, {8'h00, 4'b0110});
        else n_pass++;
        issue(3'b100, 4'h1);
        n_checks++;
        if (obs !== {8'h01, 4'b0100}) $display("FAIL redor_1: got %h want %h", obs, {8'h01, 4'b0100});
        else n_pass++;
    endtask

    task automatic test_hold();
        do_reset();
        issue(3'b001, 4'h9);
        for (int i = 0; i < 3; i++) begin
            op = 3'($urandom);
            a  = 4'($urandom);
            @(negedge clk);
            n_checks++;
            if (obs !== {8'h09, 4'b0000}) $display("FAIL hold_%0d: got %h want %h", i, obs, {8'h09, 4'b0000});
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        longint acc_m = 0;
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            int           o   = int'($urandom_range(0, 6));
            logic [W-1:0] av  = W'($urandom);
            longint       ea  = model_acc(o, longint'(av), acc_m & WMASK);
            logic         ec  = model_carry(o, longint'(av), acc_m & WMASK);
            logic [11:0]  exp_obs = {8'(ea), 1'b0, 1'b1, (ea == 0), ec};
            start = 1'b1;
            op    = 3'(o);
            a     = av;
            @(negedge clk);
            n_checks++;
            if (obs !== exp_obs) $display("FAIL b2b_%0d op%0d: got %h want %h", i, o, obs, exp_obs);
            else n_pass++;
            acc_m = ea;
        end
        start = 1'b0;
    endtask

    task automatic test_random();
        longint acc_m = 0;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            int           o   = int'($urandom_range(0, 7));
            logic [W-1:0] av  = W'($urandom);
            longint       ea  = model_acc(o, longint'(av), acc_m & WMASK);
            logic         ec  = model_carry(o, longint'(av), acc_m & WMASK);
            logic [11:0]  exp_obs = {8'(ea), 1'b0, 1'b1, (ea == 0), ec};
            issue(3'(o), av);
            if (o == 7) begin
                int cycles = 0;
                while (done !== 1'b1 && cycles < 20) begin
                    @(negedge clk);
                    cycles++;
                end
                n_checks++;
                if (cycles != W) $display("FAIL rand_mul_latency_%0d: got %0d want %0d", i, cycles, W);
                else n_pass++;
            end
            n_checks++;
            if (obs !== exp_obs) $display("FAIL rand_%0d op%0d a=%h: got %h want %h", i, o, av, obs, exp_obs);
            else n_pass++;
            acc_m = ea;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_shift();
        test_mul_abort();
        test_logic();
        test_hold();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, %0d checks made", n_checks);
        $fatal(1);
    end

endmodule
